// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and helpers that derive counter widths from it.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int UART_OVERSAMPLE_DEF = 16;
    localparam int UART_DATA_BITS_DEF  = 8;

    // Tick counter spans one bit period; the bit index needs one extra bit
    // so it can count all the way to DATA_BITS.
    function automatic int uart_cnt_w(input int oversample);
        return $clog2(oversample);
    endfunction

    function automatic int uart_idx_w(input int data_bits);
        return $clog2(data_bits) + 1;
    endfunction

    localparam int UART_CNT_W_DEF = $clog2(UART_OVERSAMPLE_DEF);
    localparam int UART_IDX_W_DEF = $clog2(UART_DATA_BITS_DEF) + 1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable
// reset value so idle-high and idle-low lines can both use it.
`timescale 1ns/1ps
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver with oversampled start detection and mid-bit sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
    parameter int DATA_BITS  = UART_DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CNT_W = uart_cnt_w(OVERSAMPLE);
    localparam int IDX_W = uart_idx_w(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 framing_err_q, framing_err_d;
    logic                 parity_bad;

`ifdef UART_RX_PARITY_EN
    logic parity_bit_q, parity_bit_d;
    logic parity_err_q, parity_err_d;

    // Even parity: the data bits together with the parity bit XOR to zero.
    assign parity_bad = (^shift_q) ^ parity_bit_q;
`else
    assign parity_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q  <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            framing_err_q <= framing_err_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q  <= parity_bit_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        framing_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d  = parity_bit_q;
        parity_err_d  = 1'b0;
`endif

        if (sample_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end

                // A start bit that is gone by mid-bit was a glitch.
                START: begin
                    if (cnt_q == CNT_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            cnt_d   = '0;
                            idx_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        cnt_d   = '0;
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        parity_bit_d = rx_s;
                        cnt_d        = '0;
                        state_d      = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif

                // Leaving at mid stop bit lets an immediately following
                // start edge be caught without losing half a bit.
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        data_d        = shift_q;
                        cnt_d         = '0;
                        state_d       = IDLE;
                        framing_err_d = !rx_s;
                        data_valid_d  = rx_s && !parity_bad;
`ifdef UART_RX_PARITY_EN
                        parity_err_d  = parity_bad;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign framing_err = framing_err_q;
    assign busy        = (state_q != IDLE);

`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames at 16 ticks per bit with a
// tick every 4 clocks and checks strobes, data and busy against hand values.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       reset;
    logic       sample_tick;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_err;
    logic       parity_err;
    logic       busy;

    int checkCount;
    int errorCount;

    int validCount;
    int framingCount;
    int parityCount;
    logic [7:0] dataQ[$];

    int v0;
    int f0;
    int p0;

    logic [1:0] tickDiv;

    uart_rx #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .rx          (rx),
        .data        (data),
        .data_valid  (data_valid),
        .framing_err (framing_err),
        .parity_err  (parity_err),
        .busy        (busy)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running oversample tick, one clk wide every fourth clk.
    always @(posedge clk) begin
        tickDiv     <= tickDiv + 2'd1;
        sample_tick <= (tickDiv == 2'd3);
    end

    // Count strobe cycles and record every delivered byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid) begin
                validCount = validCount + 1;
                dataQ.push_back(data);
            end
            if (framing_err) framingCount = framingCount + 1;
            if (parity_err)  parityCount  = parityCount + 1;
        end
    end

    // Bound the whole run so a stuck bench still ends.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (actual !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic sendBit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idleBits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    // One complete frame; in the parity build an even-parity bit is inserted,
    // optionally inverted to provoke a parity error.
    task automatic applyStimulus(input logic [7:0] value, input logic stopBit,
                                 input logic flipParity);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(value[i]);
`ifdef UART_RX_PARITY_EN
        sendBit((^value) ^ flipParity);
`else
        if (flipParity) $display("[TB] parity flip ignored in 8N1 build");
`endif
        sendBit(stopBit);
    endtask

    task automatic snapshot();
        v0 = validCount;
        f0 = framingCount;
        p0 = parityCount;
    endtask

    initial begin
        checkCount   = 0;
        errorCount   = 0;
        validCount   = 0;
        framingCount = 0;
        parityCount  = 0;
        tickDiv      = 2'd0;
        sample_tick  = 1'b0;
        rx           = 1'b1;
        reset        = 1'b1;
        repeat (5) @(negedge clk);

        checkOutput("reset_data", 32'(data), 32'h00);
        checkOutput("reset_valid", 32'(data_valid), 32'h0);
        checkOutput("reset_framing", 32'(framing_err), 32'h0);
        checkOutput("reset_parity", 32'(parity_err), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);

        reset = 1'b0;
        idleBits(2);

        // Clean 0xA5 frame.
        snapshot();
        applyStimulus(8'hA5, 1'b1, 1'b0);
        idleBits(1);
        checkOutput("a5_valid_pulses", 32'(validCount - v0), 32'd1);
        checkOutput("a5_data", 32'(data), 32'hA5);
        checkOutput("a5_framing", 32'(framingCount - f0), 32'd0);
        checkOutput("a5_busy_after", 32'(busy), 32'h0);

        // Short low glitch must be rejected at mid start bit.
        snapshot();
        rx = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("glitch_busy_rise", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("glitch_busy_fall", 32'(busy), 32'h0);
        idleBits(1);
        checkOutput("glitch_no_valid", 32'(validCount - v0), 32'd0);
        checkOutput("glitch_no_framing", 32'(framingCount - f0), 32'd0);
        checkOutput("glitch_data_held", 32'(data), 32'hA5);

        // 0x3C with a low stop bit.
        snapshot();
        applyStimulus(8'h3C, 1'b0, 1'b0);
        idleBits(2);
        checkOutput("fe_framing_pulses", 32'(framingCount - f0), 32'd1);
        checkOutput("fe_no_valid", 32'(validCount - v0), 32'd0);
        checkOutput("fe_data", 32'(data), 32'h3C);
        checkOutput("fe_busy_after", 32'(busy), 32'h0);

        // Back-to-back frames with no idle gap.
        snapshot();
        dataQ.delete();
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        idleBits(1);
        checkOutput("b2b_valid_pulses", 32'(validCount - v0), 32'd2);
        checkOutput("b2b_first", (dataQ.size() > 0) ? 32'(dataQ[0]) : 32'hDEAD, 32'h00);
        checkOutput("b2b_second", (dataQ.size() > 1) ? 32'(dataQ[1]) : 32'hDEAD, 32'hFF);
        checkOutput("b2b_framing", 32'(framingCount - f0), 32'd0);

        // Reset pulsed during data bit 4 of 0x5A.
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(logic'((8'h5A >> i) & 8'h01));
        rx = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_data", 32'(data), 32'h00);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        checkOutput("midrst_valid", 32'(data_valid), 32'h0);
        checkOutput("midrst_framing", 32'(framing_err), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        snapshot();
        idleBits(2);
        checkOutput("midrst_no_strobe", 32'(validCount - v0 + framingCount - f0), 32'd0);
        applyStimulus(8'h81, 1'b1, 1'b0);
        idleBits(1);
        checkOutput("post_rst_valid", 32'(validCount - v0), 32'd1);
        checkOutput("post_rst_data", 32'(data), 32'h81);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so the even-parity bit is 1.
        snapshot();
        applyStimulus(8'h07, 1'b1, 1'b0);
        idleBits(1);
        checkOutput("par_ok_valid", 32'(validCount - v0), 32'd1);
        checkOutput("par_ok_no_err", 32'(parityCount - p0), 32'd0);
        checkOutput("par_ok_data", 32'(data), 32'h07);

        snapshot();
        applyStimulus(8'h07, 1'b1, 1'b1);
        idleBits(1);
        checkOutput("par_bad_err", 32'(parityCount - p0), 32'd1);
        checkOutput("par_bad_no_valid", 32'(validCount - v0), 32'd0);
        checkOutput("par_bad_no_framing", 32'(framingCount - f0), 32'd0);
        checkOutput("par_bad_data", 32'(data), 32'h07);
`else
        checkOutput("no_parity_strobes", 32'(parityCount), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
